fp_mult_pipe: RTL and testbench
===============================

FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width in bits (range 4..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width in bits (range 4..52).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair present on a and b.
REQ-006 SHALL have port in_ready  output  1  block accepts the pair this cycle.
REQ-007 SHALL have port a  input  1+EXP_W+MAN_W  multiplicand, {sign, biased exponent, fraction}.
REQ-008 SHALL have port b  input  1+EXP_W+MAN_W  multiplier, same format.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port result  output  1+EXP_W+MAN_W  rounded product, same format.
REQ-012 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-013 SHALL accept a pair when in_valid and in_ready are both 1, and deliver a result when out_valid and out_ready are both 1.
REQ-014 SHALL be a 3-stage pipeline: unpack/classify, mantissa product, normalise/round/pack; with no stall, out_valid rises on the 3rd rising edge after acceptance.
REQ-015 SHALL advance all stages together when advance = !out_valid || out_ready, hold every stage register when advance = 0, and drive in_ready = advance.
REQ-016 SHALL keep result and flags stable while out_valid = 1 and out_ready = 0.
REQ-017 SHALL deliver results in acceptance order, with no loss or duplication, sustaining 1 result per cycle when out_ready stays 1.
REQ-018 SHALL set the result sign to a_sign XOR b_sign for every result except NaN.
REQ-019 SHALL treat exponent 0 (zero or subnormal) as signed zero, so subnormal inputs flush to zero without raising a flag.
REQ-020 SHALL detect NaN as exponent all-ones with nonzero fraction, and output canonical quiet NaN (sign 0, exponent all-ones, fraction MSB 1, rest 0) for any NaN input.
REQ-021 SHALL output canonical NaN with invalid = 1 for infinity times zero.
REQ-022 SHALL output signed infinity with all flags 0 for infinity times a nonzero finite value or infinity.
REQ-023 SHALL, for normal operands, form the (MAN_W+1)x(MAN_W+1) product with hidden 1s, keep a 2*MAN_W+2-bit width, and shift right 1 with exponent +1 when the top bit is set.
REQ-024 SHALL compute the unrounded exponent as ea + eb - bias (+1 on normalise), where bias = 2^(EXP_W-1)-1, in EXP_W+2 signed bits.
REQ-025 SHALL round to nearest, ties to even, using guard bit plus sticky (OR of all lower bits); a mantissa carry-out renormalises and increments the exponent.
REQ-026 SHALL output signed infinity with overflow = 1 and inexact = 1 when the rounded exponent is >= 2^EXP_W - 1.
REQ-027 SHALL output signed zero with underflow = 1 and inexact = 1 when the rounded exponent is <= 0 for nonzero operands; no subnormal output is produced.
REQ-028 SHALL set inexact = 1 when the guard or sticky bit is nonzero for a finite normal result.
REQ-029 SHALL set flags to 0 for zero, infinity and NaN-propagation results, except as given in REQ-021.

Reset
REQ-030 SHALL, with rst = 1 at a clock edge, clear all stage valid bits so that out_valid = 0, result = 0 and flags = 0 from the next cycle.
REQ-031 SHALL drop in-flight operations on reset with no later output from them, and SHALL hold in_ready = 1 the cycle after reset deasserts.
REQ-032 SHALL give rst priority over a simultaneous accept or deliver.

Verification (EXP_W=8, MAN_W=23)
REQ-033 SHALL be tested with a=0x3FC00000, b=0x40000000, out_ready=1 -> result 0x40400000 with flags 0 on the 3rd edge after accept.
REQ-034 SHALL be tested with a=0x3FC00000, b=0x3F800001 (tie) -> result 0x3FC00002 with inexact=1; and a=0x7F000000, b=0x7F000000 -> result 0x7F800000 with overflow=1 and inexact=1.
REQ-035 SHALL be tested with a=0x7F800000 * b=0x00000000, and with a=0xFF800000 * b=0x00000001 -> result 0x7FC00000 with invalid=1 in both cases.
REQ-036 SHALL be tested with a=0x00800000, b=0x3F000000 -> result 0x00000000 with underflow=1 and inexact=1; and a=0x80000000, b=0x3F800000 -> result 0x80000000 with flags 0.
REQ-037 SHALL be tested with 5 back-to-back pairs and out_ready=0 for cycles 0-6 -> exactly 3 accepted, in_ready=0 after that, result held constant, all 5 delivered in order once out_ready=1.
REQ-038 SHALL be tested with rst pulsed for 1 cycle while 2 operations are in flight -> out_valid=0 next cycle, neither result ever appears, and a fresh pair completes 3 cycles after accept.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier: unpack/classify, mantissa product, normalise/round/pack.
// Round to nearest even; subnormal inputs are treated as zero and no subnormal result is produced.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int SW = EXP_W + 2;

    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [SW-1:0] BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [SW-1:0] EXP_OVF  = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        K_NORM,
        K_ZERO,
        K_INF,
        K_NAN,
        K_INVALID
    } kind_e;

    logic advance;
    logic v1_q, v2_q, v3_q;

    kind_e                 s1_kind_d, s1_kind_q, s2_kind_q;
    logic                  s1_sign_d, s1_sign_q, s2_sign_q;
    logic signed [SW-1:0]  s1_exp_d, s1_exp_q, s2_exp_q;
    logic [MAN_W:0]        s1_ma_d, s1_ma_q, s1_mb_d, s1_mb_q;
    logic [PW-1:0]         s2_prod_d, s2_prod_q;
    logic [W-1:0]          result_d, result_q;
    logic [3:0]            flags_d, flags_q;

    // The whole pipe moves as one; a stalled output freezes every stage behind it.
    assign advance   = !v3_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // ---------------- stage 1: unpack / classify ----------------
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_exp  = a[W-2:MAN_W];
    assign b_exp  = b[W-2:MAN_W];
    assign a_frac = a[MAN_W-1:0];
    assign b_frac = b[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        s1_kind_d = K_NORM;
        if (a_nan || b_nan)
            s1_kind_d = K_NAN;
        else if ((a_inf && b_zero) || (a_zero && b_inf))
            s1_kind_d = K_INVALID;
        else if (a_inf || b_inf)
            s1_kind_d = K_INF;
        else if (a_zero || b_zero)
            s1_kind_d = K_ZERO;
    end

    assign s1_sign_d = a[W-1] ^ b[W-1];
    assign s1_exp_d  = {2'b00, a_exp} + {2'b00, b_exp} - BIAS;
    assign s1_ma_d   = {1'b1, a_frac};
    assign s1_mb_d   = {1'b1, b_frac};

    // ---------------- stage 2: mantissa product ----------------
    assign s2_prod_d = {{(MAN_W+1){1'b0}}, s1_ma_q} * {{(MAN_W+1){1'b0}}, s1_mb_q};

    // ---------------- stage 3: normalise / round / pack ----------------
    logic                 top, guard_b, sticky, round_up, carry, ovf, unf;
    logic [MAN_W-1:0]     frac_t;
    logic [MAN_W:0]       frac_sum;
    logic signed [SW-1:0] exp_r;

    // Product lies in [1,4); a set top bit means one extra right shift of the binary point.
    assign top      = s2_prod_q[PW-1];
    assign frac_t   = top ? s2_prod_q[PW-2:MAN_W+1] : s2_prod_q[PW-3:MAN_W];
    assign guard_b  = top ? s2_prod_q[MAN_W] : s2_prod_q[MAN_W-1];
    assign sticky   = top ? |s2_prod_q[MAN_W-1:0] : |s2_prod_q[MAN_W-2:0];
    assign round_up = guard_b & (sticky | frac_t[0]);
    assign frac_sum = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
    assign carry    = frac_sum[MAN_W];
    assign exp_r    = s2_exp_q + {{(SW-1){1'b0}}, top} + {{(SW-1){1'b0}}, carry};
    assign ovf      = (exp_r >= EXP_OVF);
    assign unf      = exp_r[SW-1] || (exp_r == '0);

    always_comb begin
        result_d = '0;
        flags_d  = '0;
        case (s2_kind_q)
            K_NAN:     result_d = QNAN;
            K_INVALID: begin
                result_d = QNAN;
                flags_d  = 4'b1000;
            end
            K_INF:     result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            K_ZERO:    result_d = {s2_sign_q, {(W-1){1'b0}}};
            default: begin
                if (ovf) begin
                    result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                    flags_d  = 4'b0101;
                end else if (unf) begin
                    result_d = {s2_sign_q, {(W-1){1'b0}}};
                    flags_d  = 4'b0011;
                end else begin
                    result_d = {s2_sign_q, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                    flags_d  = {3'b000, guard_b | sticky};
                end
            end
        endcase
        // Bubbles leave clean zeros on the output instead of stale datapath contents.
        if (!v2_q) begin
            result_d = '0;
            flags_d  = '0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates so each stage samples its predecessor's pre-edge value.
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (advance) begin
            v1_q     <= in_valid;
            v2_q     <= v1_q;
            v3_q     <= v2_q;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // NOTE: datapath registers are not reset; the valid bits alone decide whether they matter.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_kind_q <= s1_kind_d;
            s1_sign_q <= s1_sign_d;
            s1_exp_q  <= s1_exp_d;
            s1_ma_q   <= s1_ma_d;
            s1_mb_q   <= s1_mb_d;
            s2_kind_q <= s1_kind_q;
            s2_sign_q <= s1_sign_q;
            s2_exp_q  <= s1_exp_q;
            s2_prod_q <= s2_prod_d;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (binary32): directed corner cases, stall, reset and random traffic
// scored against an arithmetic reference model.
module tb_fp_mult_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int          total;
    int          bad;
    logic [35:0] exp_q[$];
    logic        held_valid;
    logic [31:0] held_res;
    logic [3:0]  held_flags;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product of the significands, rounded with quotient/remainder arithmetic.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        int     ex, ey, e, s;
        longint fx, fy, p, q, r, half;
        logic   sg, xn, yn, xi, yi, xz, yz;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = longint'(x[22:0]);
        fy = longint'(y[22:0]);
        sg = x[31] ^ y[31];
        xn = (ex == 255) && (fx != 0);
        yn = (ey == 255) && (fy != 0);
        xi = (ex == 255) && (fx == 0);
        yi = (ey == 255) && (fy == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        if (xn || yn) return {4'b0000, 32'h7FC00000};
        if ((xi && yz) || (xz && yi)) return {4'b1000, 32'h7FC00000};
        if (xi || yi) return {4'b0000, sg, 8'hFF, 23'h0};
        if (xz || yz) return {4'b0000, sg, 31'h0};
        p    = (fx + (longint'(1) << 23)) * (fy + (longint'(1) << 23));
        s    = (p >= (longint'(1) << 47)) ? 24 : 23;
        q    = p >> s;
        r    = p - (q << s);
        half = longint'(1) << (s - 1);
        e    = ex + ey - 127 + (s - 23);
        if (r > half || (r == half && q[0])) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            e = e + 1;
        end
        if (e >= 255) return {4'b0101, sg, 8'hFF, 23'h0};
        if (e <= 0) return {4'b0011, sg, 31'h0};
        return {3'b000, (r != 0), sg, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 9))
            0: begin e = 8'h00; if ($urandom_range(0, 1) == 0) f = '0; end
            1: begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
            2: e = 8'($urandom_range(190, 254));
            3: e = 8'($urandom_range(1, 70));
            4: begin e = 8'($urandom_range(100, 154)); f = 23'h7FFFFF ^ 23'($urandom_range(0, 3)); end
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    function automatic logic [31:0] rand_normal();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    // One clock cycle: drive at the falling edge, sample just after, score handshakes, wait for the rising edge.
    task automatic step(input logic v, input logic [31:0] av, input logic [31:0] bv,
                        input logic r, output logic acc);
        logic [35:0] e;
        @(negedge clk);
        in_valid  = v;
        a         = av;
        b         = bv;
        out_ready = r;
        #1;
        acc = in_valid && in_ready;
        if (held_valid) check("hold_valid", out_valid, 1);
        if (out_valid) begin
            if (held_valid) begin
                check("hold_result", result, held_res);
                check("hold_flags", flags, held_flags);
            end
            if (out_ready) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL spurious_out got=%h want=none", result);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_result", result, e[31:0]);
                    check("sb_flags", flags, e[35:32]);
                end
            end
            held_valid = !out_ready;
            held_res   = result;
            held_flags = flags;
        end else begin
            held_valid = 1'b0;
        end
        if (acc) exp_q.push_back(model(av, bv));
        @(posedge clk);
    endtask

    task automatic single(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] want_r, input logic [3:0] want_f);
        logic acc;
        step(1'b1, x, y, 1'b1, acc);
        check({tag, "_acc"}, acc, 1);
        step(1'b0, 32'h0, 32'h0, 1'b1, acc);
        #1;
        check({tag, "_lat2"}, out_valid, 0);
        step(1'b0, 32'h0, 32'h0, 1'b1, acc);
        #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_result"}, result, want_r);
        check({tag, "_flags"}, flags, want_f);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 32'h0, 32'h0, 1'b1, acc);
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [31:0] opa[5];
    logic [31:0] opb[5];

    initial begin
        logic acc;
        int   idx;
        int   j;
        total      = 0;
        bad        = 0;
        held_valid = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", flags, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_ready", in_ready, 1);

        single("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        single("tie_even", 32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001);
        single("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
        single("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        single("ninf_x_sub", 32'hFF800000, 32'h00000001, 32'h7FC00000, 4'b1000);
        single("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        single("neg_zero", 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
        single("nan_in", 32'hFFC12345, 32'h3F800000, 32'h7FC00000, 4'b0000);
        single("inf_x_neg", 32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000);
        drain();

        // Five pairs back to back with the consumer stalled for cycles 0..6.
        for (int i = 0; i < 5; i++) begin
            opa[i] = rand_normal();
            opb[i] = rand_normal();
        end
        idx = 0;
        for (int cyc = 0; cyc < 40 && !(idx == 5 && exp_q.size() == 0); cyc++) begin
            j = (idx < 5) ? idx : 0;
            step(idx < 5, opa[j], opb[j], cyc >= 7, acc);
            if (acc) idx++;
            if (cyc >= 3 && cyc <= 6) begin
                #1;
                check("b2b_stall_ready", in_ready, 0);
            end
            if (cyc == 6) check("b2b_accepted_3", idx, 3);
        end
        check("b2b_all_accepted", idx, 5);
        check("b2b_all_delivered", exp_q.size(), 0);

        // Reset with two operations in flight and a pair offered on the reset edge.
        step(1'b1, rand_normal(), rand_normal(), 1'b1, acc);
        step(1'b1, rand_normal(), rand_normal(), 1'b1, acc);
        check("rst_second_acc", acc, 1);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = rand_normal();
        b         = rand_normal();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        exp_q.delete();
        held_valid = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_ready_after", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, acc);
            #1;
            check("rst_no_ghost", out_valid, 0);
        end
        single("post_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        drain();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) < 7, rand_op(), rand_op(), $urandom_range(0, 9) < 7, acc);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
